cpu_core_param: RTL and testbench

- Parametrised successor of the 16-bit bus CPU top.
- Multi-cycle fetch/execute core with configurable data width, address width and register count.
- Separate instruction and data memory ports, each with a req/ready handshake so memory can insert wait states.
- Adds synchronous reset, CMP flags with conditional relative branches, and a HALT state.

---
 rtl/cpu_core_param.sv | 163 ++++++++++++++++
 tb/tb_cpu_core_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Multi-cycle parametrised CPU core: FETCH -> EXEC (-> MEM) with separate instruction/data ports.
// Latency: ALU/branch 2 cycles, LD/ST 3 cycles with zero wait states; each wait cycle adds one.
// Backpressure: i_req/d_req and their address/data are held stable until i_ready/d_ready.
module cpu_core_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                REG_COUNT = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_req,
  input  logic [15:0]       i_data,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  output logic              d_req,
  output logic              d_we,
  input  logic              d_ready,
  output logic [2:0]        flags,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8, OP_LDI = 4'h9, OP_LD  = 4'hA, OP_ST  = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC, OP_JMP = 4'hD, OP_BR  = 4'hE, OP_HLT = 4'hF;

  // Register indices at or above this limit read as zero and drop writes.
  localparam logic [4:0] REG_LIM = 5'(REG_COUNT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [16];

  logic [3:0]        op, rd, ra, rb;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] ra_val, rb_val, alu_res;
  logic              rd_ok, br_taken;
  logic [ADDR_W-1:0] pc_inc, br_off, br_tgt;
  logic [2:0]        cmp_flags;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ra   = ir[7:4];
  assign rb   = ir[3:0];
  assign imm8 = ir[7:0];

  assign ra_val = ({1'b0, ra} < REG_LIM) ? regs[ra] : '0;
  assign rb_val = ({1'b0, rb} < REG_LIM) ? regs[rb] : '0;
  assign rd_ok  = ({1'b0, rd} < REG_LIM);

  assign pc_inc = pc + ADDR_W'(1);
  assign br_off = ADDR_W'($signed(imm8));
  assign br_tgt = pc_inc + br_off;

  // {N,C,Z}: signed less-than, unsigned less-than, equality.
  assign cmp_flags = {($signed(ra_val) < $signed(rb_val)), (ra_val < rb_val), (ra_val == rb_val)};

  assign i_req   = (state == S_FETCH);
  assign i_addr  = pc;
  assign d_req   = (state == S_MEM);
  assign d_we    = (state == S_MEM) && (op == OP_ST);
  assign d_addr  = ADDR_W'(ra_val);
  assign d_wdata = rb_val;
  assign halted  = (state == S_HALTED);

  // ALU result for register-writing single-cycle opcodes.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = ra_val + rb_val;
      OP_SUB:  alu_res = ra_val - rb_val;
      OP_AND:  alu_res = ra_val & rb_val;
      OP_OR:   alu_res = ra_val | rb_val;
      OP_XOR:  alu_res = ra_val ^ rb_val;
      OP_NOT:  alu_res = ~ra_val;
      OP_SHL:  alu_res = ra_val << 1;
      OP_SHR:  alu_res = ra_val >> 1;
      OP_LDI:  alu_res = DATA_W'(imm8);
      default: alu_res = '0;
    endcase
  end

  // Branch condition decode from the low three bits of rd.
  always_comb begin
    br_taken = 1'b0;
    case (rd[2:0])
      3'd0:    br_taken = 1'b1;
      3'd1:    br_taken = flags[0];
      3'd2:    br_taken = !flags[0];
      3'd3:    br_taken = flags[1];
      3'd4:    br_taken = !flags[1];
      3'd5:    br_taken = flags[2];
      3'd6:    br_taken = !flags[2];
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state logic of the fetch/execute sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (i_ready) state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
        else if (op == OP_HLT)          state_nxt = S_HALTED;
        else                            state_nxt = S_FETCH;
      end
      S_MEM:    if (d_ready) state_nxt = S_FETCH;
      default:  state_nxt = S_HALTED;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // PC, instruction register, register file and flags updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      ir    <= '0;
      flags <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (i_ready) ir <= i_data;
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_LDI: begin
              if (rd_ok) regs[rd] <= alu_res;
              pc <= pc_inc;
            end
            OP_CMP: begin
              flags <= cmp_flags;
              pc    <= pc_inc;
            end
            OP_JMP:  pc <= ADDR_W'(ra_val);
            OP_BR:   pc <= br_taken ? br_tgt : pc_inc;
            OP_NOP:  pc <= pc_inc;
            default: pc <= pc;
          endcase
        end
        S_MEM: begin
          if (d_ready) begin
            if (op == OP_LD && rd_ok) regs[rd] <= d_rdata;
            pc <= pc_inc;
          end
        end
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: a 16-bit core (RESET_PC=0x10) and a narrow 8/12-bit core share the memory model.
// Expected fetches and data accesses are queued by the stimulus and popped by a monitor on each handshake.
// Memory wait states come from per-entry wait counts; the unselected core is held in reset.
module tb_cpu_core_param;

  typedef struct { logic [15:0] word; int iwait; } wq_t;
  typedef struct { logic [15:0] addr; logic [2:0] flg; int gap; } fq_t;
  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } dq_t;
  typedef struct { logic [15:0] rdata; int dwait; } rq_t;

  logic clk, rst_a, rst_b, sel;
  logic [15:0] i_data, d_rdata;
  logic i_ready, d_ready;

  logic [15:0] a_i_addr, a_d_addr, a_d_wdata;
  logic a_i_req, a_d_req, a_d_we, a_halted;
  logic [2:0] a_flags;
  logic [11:0] b_i_addr, b_d_addr;
  logic [7:0] b_d_wdata;
  logic b_i_req, b_d_req, b_d_we, b_halted;
  logic [2:0] b_flags;

  logic [15:0] m_i_addr, m_d_addr, m_d_wdata;
  logic m_i_req, m_d_req, m_d_we, m_halted, cur_rst;
  logic [2:0] m_flags;

  wq_t wq[$];
  fq_t fq[$];
  dq_t dq[$];
  rq_t rq[$];

  int total = 0;
  int bad = 0;

  cpu_core_param #(.DATA_W(16), .ADDR_W(16), .REG_COUNT(16), .RESET_PC(16'h0010)) u_a (
    .clk(clk), .rst(rst_a), .i_addr(a_i_addr), .i_req(a_i_req), .i_data(i_data), .i_ready(i_ready),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_rdata(d_rdata), .d_req(a_d_req), .d_we(a_d_we),
    .d_ready(d_ready), .flags(a_flags), .halted(a_halted));

  cpu_core_param #(.DATA_W(8), .ADDR_W(12), .REG_COUNT(4)) u_b (
    .clk(clk), .rst(rst_b), .i_addr(b_i_addr), .i_req(b_i_req), .i_data(i_data), .i_ready(i_ready),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_rdata(d_rdata[7:0]), .d_req(b_d_req), .d_we(b_d_we),
    .d_ready(d_ready), .flags(b_flags), .halted(b_halted));

  always_comb begin
    m_i_addr  = sel ? {4'h0, b_i_addr} : a_i_addr;
    m_d_addr  = sel ? {4'h0, b_d_addr} : a_d_addr;
    m_d_wdata = sel ? {8'h0, b_d_wdata} : a_d_wdata;
    m_i_req   = sel ? b_i_req : a_i_req;
    m_d_req   = sel ? b_d_req : a_d_req;
    m_d_we    = sel ? b_d_we : a_d_we;
    m_halted  = sel ? b_halted : a_halted;
    m_flags   = sel ? b_flags : a_flags;
    cur_rst   = sel ? rst_b : rst_a;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic instr(input logic [15:0] addr, input logic [15:0] word, input logic [2:0] flg,
                       input int iwait, input int gap);
    wq.push_back('{word: word, iwait: iwait});
    fq.push_back('{addr: addr, flg: flg, gap: gap});
  endtask

  task automatic mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] rdata, input int dwait);
    dq.push_back('{we: we, addr: addr, wdata: wdata});
    rq.push_back('{rdata: rdata, dwait: dwait});
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((fq.size() != 0 || dq.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", fq.size() + dq.size(), 0);
  endtask

  // Memory responder: decides ready/data for the coming rising edge.
  initial begin : responder
    int i_cnt, d_cnt;
    bit i_fire, d_fire;
    i_cnt = 0; d_cnt = 0; i_fire = 0; d_fire = 0;
    forever begin
      @(negedge clk);
      if (cur_rst) begin
        i_ready = 1'b0; d_ready = 1'b0;
        i_cnt = 0; d_cnt = 0; i_fire = 0; d_fire = 0;
      end else begin
        if (i_fire && wq.size() != 0) wq.delete(0);
        if (d_fire && rq.size() != 0) rq.delete(0);
        if (i_fire) i_cnt = 0;
        if (d_fire) d_cnt = 0;
        i_fire = 0; d_fire = 0;
        i_ready = 1'b0; d_ready = 1'b0;
        if (m_i_req && wq.size() != 0) begin
          if (i_cnt < wq[0].iwait) i_cnt++;
          else begin i_ready = 1'b1; i_data = wq[0].word; i_fire = 1; end
        end
        if (m_d_req && rq.size() != 0) begin
          if (d_cnt < rq[0].dwait) d_cnt++;
          else begin d_ready = 1'b1; d_rdata = rq[0].rdata; d_fire = 1; end
        end
      end
    end
  end

  // Monitor: compares every requesting cycle against the queue head, pops on handshake.
  initial begin : monitor
    int cyc, last_hs;
    cyc = 0; last_hs = -1;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (cur_rst) last_hs = -1;
      else begin
        if (m_i_req) begin
          if (fq.size() == 0) begin
            total++; bad++;
            $display("FAIL fetch_extra: fetch at %0h with none expected", m_i_addr);
          end else begin
            check("i_addr", m_i_addr, fq[0].addr);
            if (i_ready) begin
              check("flags_at_fetch", m_flags, fq[0].flg);
              if (fq[0].gap > 0 && last_hs >= 0) check("fetch_gap", cyc - last_hs, fq[0].gap);
              last_hs = cyc;
              fq.delete(0);
            end
          end
        end
        if (m_d_req) begin
          if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL data_extra: access at %0h with none expected", m_d_addr);
          end else begin
            check("d_we", m_d_we, dq[0].we);
            check("d_addr", m_d_addr, dq[0].addr);
            check("d_wdata", m_d_wdata, dq[0].wdata);
            if (d_ready) dq.delete(0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    i_data = '0; d_rdata = '0; i_ready = 1'b0; d_ready = 1'b0;

    // Program A on the 16-bit core: ALU chain, memory with waits, branches, PC wrap, logic ops, HALT.
    instr(16'h0010, 16'h9105, 3'b000, 0, 0);  // LDI r1,5
    instr(16'h0011, 16'h9203, 3'b000, 1, 3);  // LDI r2,3 (one fetch wait)
    instr(16'h0012, 16'h2312, 3'b000, 0, 2);  // SUB r3,r1,r2 -> 2
    instr(16'h0013, 16'h7330, 3'b000, 0, 2);  // SHL r3 -> 4
    instr(16'h0014, 16'hB012, 3'b000, 0, 2);  // ST [r1]=r2
    mem(1'b1, 16'h0005, 16'h0003, 16'h0000, 3);
    instr(16'h0015, 16'hA410, 3'b000, 0, 6);  // LD r4,[r1]
    mem(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 2);
    instr(16'h0016, 16'hB034, 3'b000, 0, 5);  // ST [r3]=r4
    mem(1'b1, 16'h0004, 16'hBEEF, 16'h0000, 0);
    instr(16'h0017, 16'hC021, 3'b000, 0, 3);  // CMP r2,r1
    instr(16'h0018, 16'hE3FE, 3'b110, 0, 2);  // BR C,-2 taken
    instr(16'h0017, 16'hE110, 3'b110, 0, 2);  // BR Z not taken
    instr(16'h0018, 16'h9601, 3'b110, 0, 2);  // LDI r6,1
    instr(16'h0019, 16'h2506, 3'b110, 0, 2);  // SUB r5,r0,r6 -> FFFF
    instr(16'h001A, 16'hD050, 3'b110, 0, 2);  // JMP r5
    instr(16'hFFFF, 16'h0000, 3'b110, 0, 2);  // NOP, PC wraps
    instr(16'h0000, 16'hC011, 3'b110, 0, 2);  // CMP r1,r1
    instr(16'h0001, 16'hE205, 3'b001, 0, 2);  // BR !Z not taken
    instr(16'h0002, 16'hE07F, 3'b001, 0, 2);  // BR always +0x7F
    instr(16'h0082, 16'h3712, 3'b001, 0, 2);  // AND r7 -> 1
    instr(16'h0083, 16'h4812, 3'b001, 0, 2);  // OR r8 -> 7
    instr(16'h0084, 16'h5912, 3'b001, 0, 2);  // XOR r9 -> 6
    instr(16'h0085, 16'h6A20, 3'b001, 0, 2);  // NOT r10 -> FFFC
    instr(16'h0086, 16'h8BA0, 3'b001, 0, 2);  // SHR r11 -> 7FFE
    instr(16'h0087, 16'hB078, 3'b001, 0, 2);  // ST [r7]=r8
    mem(1'b1, 16'h0001, 16'h0007, 16'h0000, 0);
    instr(16'h0088, 16'hB09B, 3'b001, 0, 3);  // ST [r9]=r11
    mem(1'b1, 16'h0006, 16'h7FFE, 16'h0000, 1);
    instr(16'h0089, 16'hB0A9, 3'b001, 0, 4);  // ST [r10]=r9
    mem(1'b1, 16'hFFFC, 16'h0006, 16'h0000, 0);
    instr(16'h008A, 16'hF000, 3'b001, 0, 3);  // HALT

    repeat (2) @(posedge clk);
    #2 rst_a = 1'b0;
    @(negedge clk);
    #1;
    check("rst_i_req", a_i_req, 1'b1);
    check("rst_i_addr", a_i_addr, 16'h0010);
    check("rst_flags", a_flags, 3'b000);
    check("rst_halted", a_halted, 1'b0);
    check("rst_d_req", a_d_req, 1'b0);

    drain(600);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("halt_quiet", {a_halted, a_i_req, a_d_req}, 3'b100);
    end

    // Program B on the narrow core: 8-bit wrap, out-of-range register, JMP truncation.
    @(posedge clk);
    #2 sel = 1'b1;
    instr(16'h0000, 16'h91FF, 3'b000, 0, 0);  // LDI r1,FF
    instr(16'h0001, 16'h9201, 3'b000, 0, 2);  // LDI r2,1
    instr(16'h0002, 16'h1312, 3'b000, 0, 2);  // ADD r3 -> 00
    instr(16'h0003, 16'h9577, 3'b000, 0, 2);  // LDI r5 ignored
    instr(16'h0004, 16'hB035, 3'b000, 0, 2);  // ST [r3]=r5
    mem(1'b1, 16'h0000, 16'h0000, 16'h0000, 0);
    instr(16'h0005, 16'h91AB, 3'b000, 0, 3);  // LDI r1,AB
    instr(16'h0006, 16'hD010, 3'b000, 0, 2);  // JMP r1
    instr(16'h00AB, 16'hF000, 3'b000, 0, 2);  // HALT
    @(posedge clk);
    #2 rst_b = 1'b0;
    drain(300);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("narrow_halted", {b_halted, b_i_req, b_d_req}, 3'b100);

    // Reset during a stalled load on the 16-bit core.
    @(posedge clk);
    #2 sel = 1'b0; rst_a = 1'b1;
    instr(16'h0010, 16'h9105, 3'b000, 0, 0);
    instr(16'h0011, 16'hA210, 3'b000, 0, 2);
    mem(1'b0, 16'h0005, 16'h0000, 16'h1234, 1000);
    @(posedge clk);
    #2 rst_a = 1'b0;
    n = 0;
    while (!a_d_req && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ld_stall_reached", a_d_req, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b1;
    @(negedge clk);
    #1;
    check("ld_held_before_rst", a_d_req, 1'b1);
    @(negedge clk);
    #1;
    check("rst_drops_d_req", a_d_req, 1'b0);
    check("rst_refetch_req", a_i_req, 1'b1);
    check("rst_refetch_addr", a_i_addr, 16'h0010);
    fq.delete(); dq.delete(); wq.delete(); rq.delete();
    instr(16'h0010, 16'hF000, 3'b000, 0, 0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    drain(100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("restart_halted", a_halted, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
